vga_scanout: RTL and testbench

VGA_SCANOUT -- requirements
Module: vga_scanout

---
 rtl/vga_scanout.sv | 199 +++++++++++++++++++
 tb/tb_vga_scanout.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/vga_scanout.sv
// VGA scan-out of a 64x32 / 128x64 monochrome framebuffer onto a 640-wide, 320-line playfield.
// Optional macro SCANLINES_EN halves colour intensity on odd playfield lines.
module vga_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int V_OFFSET = 80,
  parameter int COLOR_W  = 6
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   hires,
  input  logic [3*COLOR_W-1:0]   fg_rgb,
  input  logic [3*COLOR_W-1:0]   bg_rgb,
  output logic [9:0]             fb_addr,
  input  logic [7:0]             fb_data,
  output logic                   vga_hs,
  output logic                   vga_vs,
  output logic [COLOR_W-1:0]     vga_r,
  output logic [COLOR_W-1:0]     vga_g,
  output logic [COLOR_W-1:0]     vga_b,
  output logic                   frame_start
);

  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(HT);
  localparam int VW = $clog2(VT);

  localparam logic [HW-1:0] H_LAST = HW'(HT - 1);
  localparam logic [HW-1:0] H_VIS  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [HW-1:0] H_LEAD = HW'(2);
  localparam logic [VW-1:0] V_LAST = VW'(VT - 1);
  localparam logic [VW-1:0] V_VIS  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [VW-1:0] PF_TOP = VW'(V_OFFSET);
  localparam logic [VW-1:0] PF_END = VW'(V_OFFSET + 320);

  logic [HW-1:0] hc_q, hc_d, ha_q, ha_d;
  logic [VW-1:0] vc_q, vc_d, va_q, va_d;
  logic          mode_q, mode_d;
  logic [3:0]    xs_q, xs_d, ys_q, ys_d, smax;
  logic [6:0]    px_q, px_d;
  logic [5:0]    py_q, py_d;
  logic [9:0]    addr_q, addr_d;
  logic [7:0]    sr_q, sr_d;
  logic [2:0]    pf_dl_q, pf_dl_d;
  logic [1:0]    ld_dl_q, ld_dl_d, sh_dl_q, sh_dl_d;
  logic          hs1_q, hs1_d, vs1_q, vs1_d, fs1_q, fs1_d, act1_q, act1_d;
  logic          hs_q, vs_q, fs_q;
  logic [3*COLOR_W-1:0] rgb_q, rgb_d, pix;
  logic          pf_now, first;
`ifdef SCANLINES_EN
  localparam logic [3*COLOR_W-1:0] DIM_MASK = {3{1'b0, {(COLOR_W-1){1'b1}}}};
  logic [2:0]    odd_dl_q, odd_dl_d;
`endif

  always_comb begin
    smax = mode_q ? 4'd4 : 4'd9;

    hc_d = (hc_q == H_LAST) ? '0 : hc_q + HW'(1);
    vc_d = vc_q;
    if (hc_q == H_LAST) vc_d = (vc_q == V_LAST) ? '0 : vc_q + VW'(1);

    // (ha,va) runs two clocks ahead of (hc,vc) so each byte arrives exactly when its first pixel needs it
    ha_d = (ha_q == H_LAST) ? '0 : ha_q + HW'(1);
    va_d = va_q;
    if (ha_q == H_LAST) va_d = (va_q == V_LAST) ? '0 : va_q + VW'(1);

    mode_d = (hc_q == '0 && vc_q == '0) ? hires : mode_q;

    xs_d = xs_q;
    px_d = px_q;
    if (ha_q == H_LAST) begin
      xs_d = '0;
      px_d = '0;
    end else if (xs_q >= smax) begin
      xs_d = '0;
      px_d = px_q + 7'd1;
    end else begin
      xs_d = xs_q + 4'd1;
    end

    ys_d = ys_q;
    py_d = py_q;
    if (ha_q == H_LAST) begin
      if (va_d == PF_TOP) begin
        ys_d = '0;
        py_d = '0;
      end else if (ys_q >= smax) begin
        ys_d = '0;
        py_d = py_q + 6'd1;
      end else begin
        ys_d = ys_q + 4'd1;
      end
    end

    pf_now = (ha_q < H_VIS) && (va_q >= PF_TOP) && (va_q < PF_END);
    first  = (xs_q == '0);

    addr_d = addr_q;
    if (pf_now && first && px_q[2:0] == 3'd0)
      addr_d = mode_q ? {py_q, px_q[6:3]} : {2'b00, py_q[4:0], px_q[5:3]};

    pf_dl_d = {pf_dl_q[1:0], pf_now};
    ld_dl_d = {ld_dl_q[0], pf_now && first && px_q[2:0] == 3'd0};
    sh_dl_d = {sh_dl_q[0], pf_now && first && px_q[2:0] != 3'd0};

    sr_d = sr_q;
    if (ld_dl_q[1])      sr_d = fb_data;
    else if (sh_dl_q[1]) sr_d = {sr_q[6:0], 1'b0};

    hs1_d  = !((hc_q >= HS_BEG) && (hc_q <= HS_END));
    vs1_d  = !((vc_q >= VS_BEG) && (vc_q <= VS_END));
    fs1_d  = (hc_q == '0) && (vc_q == '0);
    act1_d = (hc_q < H_VIS) && (vc_q < V_VIS);

    pix   = sr_q[7] ? fg_rgb : bg_rgb;
    rgb_d = '0;
    if (act1_q) rgb_d = pf_dl_q[2] ? pix : bg_rgb;
`ifdef SCANLINES_EN
    odd_dl_d = {odd_dl_q[1:0], va_q[0] ^ PF_TOP[0]};
    if (act1_q && pf_dl_q[2] && odd_dl_q[2]) rgb_d = (rgb_d >> 1) & DIM_MASK;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hc_q    <= '0;
      vc_q    <= '0;
      ha_q    <= H_LEAD;
      va_q    <= '0;
      mode_q  <= 1'b0;
      xs_q    <= '0;
      px_q    <= '0;
      ys_q    <= '0;
      py_q    <= '0;
      addr_q  <= '0;
      sr_q    <= '0;
      pf_dl_q <= '0;
      ld_dl_q <= '0;
      sh_dl_q <= '0;
      hs1_q   <= 1'b1;
      vs1_q   <= 1'b1;
      fs1_q   <= 1'b0;
      act1_q  <= 1'b0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      fs_q    <= 1'b0;
      rgb_q   <= '0;
`ifdef SCANLINES_EN
      odd_dl_q <= '0;
`endif
    end else begin
      hc_q    <= hc_d;
      vc_q    <= vc_d;
      ha_q    <= ha_d;
      va_q    <= va_d;
      mode_q  <= mode_d;
      xs_q    <= xs_d;
      px_q    <= px_d;
      ys_q    <= ys_d;
      py_q    <= py_d;
      addr_q  <= addr_d;
      sr_q    <= sr_d;
      pf_dl_q <= pf_dl_d;
      ld_dl_q <= ld_dl_d;
      sh_dl_q <= sh_dl_d;
      hs1_q   <= hs1_d;
      vs1_q   <= vs1_d;
      fs1_q   <= fs1_d;
      act1_q  <= act1_d;
      hs_q    <= hs1_q;
      vs_q    <= vs1_q;
      fs_q    <= fs1_q;
      rgb_q   <= rgb_d;
`ifdef SCANLINES_EN
      odd_dl_q <= odd_dl_d;
`endif
    end
  end

  assign fb_addr     = addr_q;
  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign frame_start = fs_q;
  assign vga_r       = rgb_q[3*COLOR_W-1:2*COLOR_W];
  assign vga_g       = rgb_q[2*COLOR_W-1:COLOR_W];
  assign vga_b       = rgb_q[COLOR_W-1:0];

endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench for vga_scanout with a shrunk raster (88 x 330) and a 1-clk-latency framebuffer model.
module tb_vga_scanout;

  localparam int HT = 88;
  localparam int VT = 330;
  localparam int FT = HT * VT;
  localparam logic [17:0] FG = {6'h3E, 6'h2A, 6'h15};
  localparam logic [17:0] BG = {6'h05, 6'h0A, 6'h11};

  logic        clk = 1'b0;
  logic        reset_n;
  logic        hires;
  logic [17:0] fg_rgb, bg_rgb;
  logic [9:0]  fb_addr;
  logic [7:0]  fb_data;
  logic        vga_hs, vga_vs, frame_start;
  logic [5:0]  vga_r, vga_g, vga_b;
  logic [17:0] rgb;
  logic [7:0]  mem [1024];

  int n_chk = 0;
  int n_fail = 0;
  int ncyc = 0;
  int fbase = 0;

  vga_scanout #(
    .H_ACTIVE(80), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(325), .V_FP(2), .V_SYNC(2), .V_BP(1),
    .V_OFFSET(3), .COLOR_W(6)
  ) dut (
    .clk(clk), .reset_n(reset_n), .hires(hires),
    .fg_rgb(fg_rgb), .bg_rgb(bg_rgb),
    .fb_addr(fb_addr), .fb_data(fb_data),
    .vga_hs(vga_hs), .vga_vs(vga_vs),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;
  always @(posedge clk) fb_data <= mem[fb_addr];
  assign rgb = {vga_r, vga_g, vga_b};

  // kind: 0 blank, 1 background, 2 foreground
  function automatic logic [17:0] col(input int kind, input int v);
    logic [17:0] c;
    c = (kind == 2) ? FG : ((kind == 1) ? BG : 18'h0);
`ifdef SCANLINES_EN
    if (kind != 0 && v >= 3 && v <= 322 && ((v - 3) % 2) == 1)
      c = {1'b0, c[17:13], 1'b0, c[11:7], 1'b0, c[5:1]};
`endif
    return c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to the sample point where the outputs show raster position (h,v) of the current frame.
  task automatic goto(input int h, input int v);
    int t;
    t = fbase + v * HT + h + 2;
    while (ncyc < t) begin
      @(negedge clk);
      ncyc++;
    end
  endtask

  task automatic px(input int h, input int v, input int kind, input string tag);
    goto(h, v);
    chk(tag, 32'(rgb), 32'(col(kind, v)));
  endtask

  initial begin
    foreach (mem[i]) mem[i] = 8'h00;
    mem[0]   = 8'h80;
    mem[8]   = 8'h41;
    mem[16]  = 8'h01;
    mem[17]  = 8'h80;
    mem[160] = 8'h80;
    mem[248] = 8'h80;
    reset_n = 1'b0;
    hires   = 1'b0;
    fg_rgb  = FG;
    bg_rgb  = BG;

    repeat (3) @(negedge clk);
    chk("rst_hs", 32'(vga_hs), 32'd1);
    chk("rst_vs", 32'(vga_vs), 32'd1);
    chk("rst_rgb", 32'(rgb), 32'd0);
    chk("rst_fs", 32'(frame_start), 32'd0);
    chk("rst_addr", 32'(fb_addr), 32'd0);

    reset_n = 1'b1;
    ncyc = 0;
    @(negedge clk); ncyc++;
    chk("fs_before", 32'(frame_start), 32'd0);

    // frame A, lo-res
    goto(0, 0);  chk("fs_A", 32'(frame_start), 32'd1);
    px(0, 0, 1, "bg_line0");
    goto(1, 0);  chk("fs_A_end", 32'(frame_start), 32'd0);
    px(80, 0, 0, "blank_h80");
    goto(81, 0); chk("hs_81", 32'(vga_hs), 32'd1);
    goto(82, 0); chk("hs_82", 32'(vga_hs), 32'd0);
    goto(85, 0); chk("hs_85", 32'(vga_hs), 32'd0);
    goto(86, 0); chk("hs_86", 32'(vga_hs), 32'd1);
    px(0, 2, 1, "above_pf");
    px(0, 3, 2, "lo_r0_h0");
    px(9, 3, 2, "lo_r0_h9");
    px(10, 3, 1, "lo_r0_h10");
    px(79, 3, 1, "lo_r0_h79");
    px(80, 3, 0, "lo_blank");
    px(0, 4, 2, "lo_line4");
    px(5, 12, 2, "lo_r0_last");
    px(0, 13, 1, "lo_r1_h0");
    px(10, 13, 2, "lo_r1_h10");
    px(19, 13, 2, "lo_r1_h19");
    px(20, 13, 1, "lo_r1_h20");
    px(69, 22, 1, "lo_r1_h69");
    px(70, 22, 2, "lo_r1_h70");
    px(79, 22, 2, "lo_r1_h79");
    px(75, 30, 2, "lo_r2_h75");
    px(75, 33, 1, "lo_r3_h75");
    goto(0, 200); hires = 1'b1;
    px(5, 210, 2, "mode_hold");
    px(10, 210, 1, "mode_hold_bg");
    px(0, 322, 2, "lo_last_line");
    goto(40, 322); chk("addr_lo_max", 32'(fb_addr), 32'd248);
    px(0, 323, 1, "below_pf");
    px(0, 325, 0, "blank_v325");
    goto(0, 326); chk("vs_326", 32'(vga_vs), 32'd1);
    goto(0, 327); chk("vs_327", 32'(vga_vs), 32'd0);
    goto(87, 328); chk("vs_328", 32'(vga_vs), 32'd0);
    goto(0, 329); chk("vs_329", 32'(vga_vs), 32'd1);

    // frame B, hi-res
    fbase = FT;
    goto(0, 0); chk("fs_B", 32'(frame_start), 32'd1);
    px(0, 3, 2, "hi_r0_h0");
    px(5, 3, 1, "hi_r0_h5");
    px(4, 7, 2, "hi_r0_h4");
    px(4, 8, 1, "hi_r1_h4");
    goto(20, 10); chk("addr_hi_16", 32'(fb_addr), 32'd16);
    px(34, 10, 1, "hi_r1_h34");
    px(35, 10, 2, "hi_r1_h35");
    goto(40, 10); chk("addr_hi_17", 32'(fb_addr), 32'd17);
    px(40, 10, 2, "hi_r1_h40");
    px(39, 12, 2, "hi_r1_h39");
    px(45, 12, 1, "hi_r1_h45");
    px(35, 13, 1, "hi_r2_h35");
    px(2, 55, 2, "hi_r10_h2");

    // reset mid-line during horizontal sync
    goto(83, 60); chk("hs_pre_rst", 32'(vga_hs), 32'd0);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_hs", 32'(vga_hs), 32'd1);
    chk("mid_rst_vs", 32'(vga_vs), 32'd1);
    chk("mid_rst_rgb", 32'(rgb), 32'd0);
    chk("mid_rst_fs", 32'(frame_start), 32'd0);
    chk("mid_rst_addr", 32'(fb_addr), 32'd0);
    repeat (3) @(negedge clk);
    chk("rst_hold_hs", 32'(vga_hs), 32'd1);
    hires   = 1'b0;
    reset_n = 1'b1;
    ncyc  = 0;
    fbase = 0;
    @(negedge clk); ncyc++;
    chk("fs_rel_1", 32'(frame_start), 32'd0);
    @(negedge clk); ncyc++;
    chk("fs_rel_2", 32'(frame_start), 32'd1);
    px(5, 8, 2, "lo_after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
